// File: rtl/flght_seq_if.sv
// Sequencer <-> cmd_cfg/inertial/flght_cntrl signal bundle.
// The slave modport is the sequencer side; the master modport is its environment.
interface flght_seq_if;
  logic       strt_cal;
  logic       cal_done;
  logic       motors_off;
  logic       vld;
  logic [8:0] thrst_cmd;
  logic       strt_cal_inert;
  logic       inertial_cal;
  logic [8:0] thrst;
  logic       armed;
  logic       fault;

  modport master (
    output strt_cal, cal_done, motors_off, vld, thrst_cmd,
    input  strt_cal_inert, inertial_cal, thrst, armed, fault
  );

  modport slave (
    input  strt_cal, cal_done, motors_off, vld, thrst_cmd,
    output strt_cal_inert, inertial_cal, thrst, armed, fault
  );
endinterface

// File: rtl/flght_seq.sv
// Motor-arming sequencer: calibration supervision, thrust slew on arming, vld watchdog, kill.
// All outputs registered (1-cycle latency); no backpressure, progress is paced by vld/cal_done.
module flght_seq #(
  parameter int TMR_W      = 20,
  parameter int CAL_TMO    = 1000000,
  parameter int WDOG_LIMIT = 200000,
  parameter int RAMP_STEP  = 4
) (
  input logic        clk,
  input logic        rst,
  flght_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CAL_REQ  = 3'd1,
    CAL_WAIT = 3'd2,
    RAMP     = 3'd3,
    RUN      = 3'd4,
    FAULT    = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [8:0]         thrst_q, thrst_d;
  logic               sci_q, ic_q, armed_q, fault_q;
  logic               cal_exp, wdog_exp, wdog_trip;
  logic [9:0]         ramp_tgt;

  assign cal_exp   = (timer_q == TMR_W'(CAL_TMO - 1));
  assign wdog_exp  = (timer_q == TMR_W'(WDOG_LIMIT - 1));
  assign wdog_trip = wdog_exp && !bus.vld;
  // Widened so thrst+step near the top of range cannot wrap and re-arm the ramp.
  assign ramp_tgt  = {1'b0, thrst_q} + 10'(RAMP_STEP);

  always_comb begin
    state_d = state_q;
    thrst_d = thrst_q;
    case (state_q)
      IDLE: begin
        thrst_d = '0;
        if (bus.strt_cal) state_d = CAL_REQ;
      end
      CAL_REQ: begin
        thrst_d = '0;
        state_d = CAL_WAIT;
      end
      CAL_WAIT: begin
        thrst_d = '0;
        if (bus.cal_done)  state_d = RAMP;
        else if (cal_exp)  state_d = FAULT;
      end
      RAMP: begin
        if (wdog_trip) begin
          state_d = FAULT;
          thrst_d = '0;
        end else if (bus.vld) begin
          if ({1'b0, bus.thrst_cmd} > ramp_tgt) begin
            thrst_d = thrst_q + 9'(RAMP_STEP);
          end else begin
            thrst_d = bus.thrst_cmd;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (wdog_trip) begin
          state_d = FAULT;
          thrst_d = '0;
        end else begin
          thrst_d = bus.thrst_cmd;
        end
      end
      FAULT: begin
        thrst_d = '0;
      end
      default: begin
        state_d = IDLE;
        thrst_d = '0;
      end
    endcase
    if (bus.motors_off) begin
      state_d = IDLE;
      thrst_d = '0;
    end
  end

  always_comb begin
    timer_d = timer_q;
    if ((state_d != state_q) || (((state_q == RAMP) || (state_q == RUN)) && bus.vld)) begin
      timer_d = '0;
    end else if (timer_q != {TMR_W{1'b1}}) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      thrst_q <= '0;
      sci_q   <= 1'b0;
      ic_q    <= 1'b0;
      armed_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      thrst_q <= thrst_d;
      sci_q   <= (state_d == CAL_REQ);
      ic_q    <= (state_d == CAL_REQ) || (state_d == CAL_WAIT);
      armed_q <= (state_d == RAMP) || (state_d == RUN);
      fault_q <= (state_d == FAULT);
    end
  end

  assign bus.strt_cal_inert = sci_q;
  assign bus.inertial_cal   = ic_q;
  assign bus.thrst          = thrst_q;
  assign bus.armed          = armed_q;
  assign bus.fault          = fault_q;

endmodule

// File: tb/tb_flght_seq.sv
// Directed + randomized bench for flght_seq with a scenario-level thrust/timing model.
module tb_flght_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  flght_seq_if bus ();

  flght_seq #(
    .TMR_W     (20),
    .CAL_TMO   (16),
    .WDOG_LIMIT(8),
    .RAMP_STEP (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, want finish before 500000");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_thrst"}, {1'b0, bus.thrst}, 10'd0);
    chk({tag, "_armed"}, {9'd0, bus.armed}, 10'd0);
    chk({tag, "_fault"}, {9'd0, bus.fault}, 10'd0);
    chk({tag, "_ical"},  {9'd0, bus.inertial_cal}, 10'd0);
    chk({tag, "_sci"},   {9'd0, bus.strt_cal_inert}, 10'd0);
  endtask

  task automatic kill(input string tag);
    bus.motors_off = 1'b1;
    tick();
    bus.motors_off = 1'b0;
    chk({tag, "_kill_armed"}, {9'd0, bus.armed}, 10'd0);
    chk({tag, "_kill_fault"}, {9'd0, bus.fault}, 10'd0);
    chk({tag, "_kill_thrst"}, {1'b0, bus.thrst}, 10'd0);
  endtask

  // From IDLE through calibration into the ramp, cal_done right after CAL_WAIT entry.
  task automatic arm();
    bus.strt_cal = 1'b1;
    tick();
    bus.strt_cal = 1'b0;
    tick();
    bus.cal_done = 1'b1;
    tick();
    bus.cal_done = 1'b0;
    chk("arm_armed", {9'd0, bus.armed}, 10'd1);
    chk("arm_ical",  {9'd0, bus.inertial_cal}, 10'd0);
  endtask

  // Thrust starts at zero and climbs by the step per reading until the command is in reach.
  task automatic ramp_to_run(input int cmd);
    int  expv;
    bit  done;
    int  gap;
    int  c2;
    expv = 0;
    done = 1'b0;
    bus.thrst_cmd = 9'(cmd);
    while (!done) begin
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        tick();
        chk("ramp_hold", {1'b0, bus.thrst}, 10'(expv));
      end
      bus.vld = 1'b1;
      tick();
      bus.vld = 1'b0;
      if (cmd > expv + 4) expv = expv + 4;
      else begin
        expv = cmd;
        done = 1'b1;
      end
      chk("ramp_step", {1'b0, bus.thrst}, 10'(expv));
      chk("ramp_armed", {9'd0, bus.armed}, 10'd1);
    end
    c2 = int'($urandom_range(0, 511));
    bus.thrst_cmd = 9'(c2);
    tick();
    chk("run_follow", {1'b0, bus.thrst}, 10'(c2));
  endtask

  initial begin
    int c;
    int expl[3];
    bus.strt_cal   = 1'b0;
    bus.cal_done   = 1'b0;
    bus.motors_off = 1'b0;
    bus.vld        = 1'b0;
    bus.thrst_cmd  = '0;

    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // strt_cal together with motors_off stays idle
    bus.strt_cal   = 1'b1;
    bus.motors_off = 1'b1;
    tick();
    bus.strt_cal   = 1'b0;
    bus.motors_off = 1'b0;
    tick();
    chk("idle_kill_sci",  {9'd0, bus.strt_cal_inert}, 10'd0);
    chk("idle_kill_ical", {9'd0, bus.inertial_cal}, 10'd0);

    // 1. normal arm
    bus.strt_cal = 1'b1;
    tick();
    bus.strt_cal = 1'b0;
    chk("calreq_sci",  {9'd0, bus.strt_cal_inert}, 10'd1);
    chk("calreq_ical", {9'd0, bus.inertial_cal}, 10'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("calwait_sci",   {9'd0, bus.strt_cal_inert}, 10'd0);
      chk("calwait_ical",  {9'd0, bus.inertial_cal}, 10'd1);
      chk("calwait_thrst", {1'b0, bus.thrst}, 10'd0);
    end
    bus.cal_done = 1'b1;
    tick();
    bus.cal_done = 1'b0;
    chk("caldone_ical",  {9'd0, bus.inertial_cal}, 10'd0);
    chk("caldone_armed", {9'd0, bus.armed}, 10'd1);
    bus.thrst_cmd = 9'd10;
    expl = '{4, 8, 10};
    for (int i = 0; i < 3; i++) begin
      tick();
      tick();
      chk("arm_gap_armed", {9'd0, bus.armed}, 10'd1);
      bus.vld = 1'b1;
      tick();
      bus.vld = 1'b0;
      chk("arm_ramp_thrst", {1'b0, bus.thrst}, 10'(expl[i]));
    end
    c = int'($urandom_range(0, 511));
    bus.thrst_cmd = 9'(c);
    tick();
    chk("arm_run_follow", {1'b0, bus.thrst}, 10'(c));
    chk("arm_run_armed",  {9'd0, bus.armed}, 10'd1);

    // 4. watchdog in RUN
    bus.thrst_cmd = 9'd200;
    bus.vld = 1'b1;
    tick();
    bus.vld = 1'b0;
    chk("wd_thrst200", {1'b0, bus.thrst}, 10'd200);
    for (int k = 1; k < 8; k++) begin
      tick();
      chk("wd_pre_fault", {9'd0, bus.fault}, 10'd0);
    end
    tick();
    chk("wd_fault", {9'd0, bus.fault}, 10'd1);
    chk("wd_thrst", {1'b0, bus.thrst}, 10'd0);
    chk("wd_armed", {9'd0, bus.armed}, 10'd0);
    bus.strt_cal = 1'b1;
    tick();
    bus.strt_cal = 1'b0;
    chk("fault_sticky_sci",   {9'd0, bus.strt_cal_inert}, 10'd0);
    chk("fault_sticky_fault", {9'd0, bus.fault}, 10'd1);
    kill("wd");

    // 4b. vld on the expiry cycle rescues
    arm();
    ramp_to_run(int'($urandom_range(0, 511)));
    bus.vld = 1'b1;
    tick();
    bus.vld = 1'b0;
    for (int k = 1; k < 8; k++) tick();
    bus.vld = 1'b1;
    tick();
    bus.vld = 1'b0;
    chk("wd_save_fault", {9'd0, bus.fault}, 10'd0);
    chk("wd_save_armed", {9'd0, bus.armed}, 10'd1);
    for (int k = 1; k < 8; k++) tick();
    chk("wd_save_pre", {9'd0, bus.fault}, 10'd0);
    tick();
    chk("wd_save_late_fault", {9'd0, bus.fault}, 10'd1);
    kill("wd2");

    // 2. calibration timeout
    bus.strt_cal = 1'b1;
    tick();
    bus.strt_cal = 1'b0;
    tick();
    for (int k = 1; k < 16; k++) begin
      tick();
      chk("caltmo_pre", {9'd0, bus.fault}, 10'd0);
    end
    tick();
    chk("caltmo_fault", {9'd0, bus.fault}, 10'd1);
    chk("caltmo_thrst", {1'b0, bus.thrst}, 10'd0);
    chk("caltmo_ical",  {9'd0, bus.inertial_cal}, 10'd0);
    kill("caltmo");

    // 3. cal_done on the timeout cycle wins; then ramp to the top of range
    bus.strt_cal = 1'b1;
    tick();
    bus.strt_cal = 1'b0;
    tick();
    for (int k = 1; k < 16; k++) tick();
    bus.cal_done = 1'b1;
    tick();
    bus.cal_done = 1'b0;
    chk("calbnd_fault", {9'd0, bus.fault}, 10'd0);
    chk("calbnd_armed", {9'd0, bus.armed}, 10'd1);
    ramp_to_run(511);
    kill("calbnd");

    // 5. ramp with reduction
    arm();
    bus.thrst_cmd = 9'd20;
    for (int i = 1; i <= 2; i++) begin
      bus.vld = 1'b1;
      tick();
      bus.vld = 1'b0;
      chk("red_ramp", {1'b0, bus.thrst}, 10'(4 * i));
    end
    bus.thrst_cmd = 9'd3;
    tick();
    chk("red_hold", {1'b0, bus.thrst}, 10'd8);
    bus.vld = 1'b1;
    tick();
    bus.vld = 1'b0;
    chk("red_drop", {1'b0, bus.thrst}, 10'd3);
    bus.thrst_cmd = 9'd511;
    tick();
    chk("red_run511", {1'b0, bus.thrst}, 10'd511);
    kill("red");

    // 6. kill mid-ramp, then async reset mid-run
    arm();
    bus.thrst_cmd = 9'd100;
    bus.vld = 1'b1;
    tick();
    bus.vld = 1'b0;
    chk("kr_ramp", {1'b0, bus.thrst}, 10'd4);
    kill("midramp");
    chk("midramp_ical", {9'd0, bus.inertial_cal}, 10'd0);
    arm();
    ramp_to_run(int'($urandom_range(0, 511)));
    bus.thrst_cmd = 9'd300;
    tick();
    chk("ar_run300", {1'b0, bus.thrst}, 10'd300);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("post_rst_armed", {9'd0, bus.armed}, 10'd0);
    chk("post_rst_thrst", {1'b0, bus.thrst}, 10'd0);

    // randomized full cycles
    for (int r = 0; r < 3; r++) begin
      arm();
      ramp_to_run(int'($urandom_range(0, 511)));
      kill("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
